id_regfile_sb: RTL and testbench

ID_REGFILE_SB -- requirements
Module: id_regfile_sb

---
 rtl/id_regfile_sb.sv | 104 ++++++++++
 tb/tb_id_regfile_sb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/id_regfile_sb.sv
// ID-stage register file with per-register in-flight write scoreboard: combinational reads with WB bypass,
// zero-cycle stall/issue; a stalled instruction is turned into a bubble toward ID/EX.
module id_regfile_sb #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 8,
  parameter int MAX_INFL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [2:0]        R1_addr,
  input  logic [2:0]        R2_addr,
  input  logic              R1_use,
  input  logic              R2_use,
  input  logic              WRegEn_in,
  input  logic              WMemEn_in,
  input  logic [2:0]        WReg1_in,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] R1_out_ID,
  output logic [DATA_W-1:0] R2_out_ID,
  output logic              WRegEn_ID,
  output logic              WMemEn_ID,
  output logic [2:0]        WReg1_ID,
  output logic              issue,
  output logic              stall,
  output logic              sb_err
);

  localparam int         NADDR   = 8;
  localparam logic [1:0] CNT_MAX = 2'(MAX_INFL);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [1:0]        cnt  [DEPTH];
  logic              sb_err_q;

  // Full 3-bit address map; slots beyond DEPTH read as an idle, zero register.
  logic [DATA_W-1:0] reg_at [NADDR];
  logic [1:0]        cnt_at [NADDR];

  for (genvar g = 0; g < NADDR; g++) begin : g_map
    if (g < DEPTH) begin : g_live
      assign reg_at[g] = regs[g];
      assign cnt_at[g] = cnt[g];
    end else begin : g_dead
      assign reg_at[g] = '0;
      assign cnt_at[g] = '0;
    end
  end

  logic hz_r1, hz_r2, dst_full;
  logic wb_hit_r1, wb_hit_r2;

  always_comb begin
    wb_hit_r1 = wb_en && (wb_addr == R1_addr);
    wb_hit_r2 = wb_en && (wb_addr == R2_addr);
    // A writeback retiring the last outstanding write clears the hazard in the same cycle.
    hz_r1     = (cnt_at[R1_addr] != 2'd0) && !(wb_hit_r1 && cnt_at[R1_addr] == 2'd1);
    hz_r2     = (cnt_at[R2_addr] != 2'd0) && !(wb_hit_r2 && cnt_at[R2_addr] == 2'd1);
    dst_full  = (cnt_at[WReg1_in] == CNT_MAX);
  end

  assign stall     = id_valid && ((R1_use && hz_r1) || (R2_use && hz_r2) || (WRegEn_in && dst_full));
  assign issue     = id_valid && !stall;
  assign R1_out_ID = wb_hit_r1 ? wb_data : reg_at[R1_addr];
  assign R2_out_ID = wb_hit_r2 ? wb_data : reg_at[R2_addr];
  assign WRegEn_ID = issue && WRegEn_in;
  assign WMemEn_ID = issue && WMemEn_in;
  assign WReg1_ID  = WReg1_in;
  assign sb_err    = sb_err_q;

  logic [DEPTH-1:0] cnt_inc, cnt_dec;
  logic             wb_orphan;

  always_comb begin
    cnt_inc   = '0;
    cnt_dec   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_inc[i] = issue && WRegEn_in && (int'(WReg1_in) == i);
      cnt_dec[i] = wb_en && (int'(wb_addr) == i) && (cnt[i] != 2'd0);
    end
    wb_orphan = wb_en && (cnt_at[wb_addr] == 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (wb_en && (int'(wb_addr) < DEPTH)) regs[wb_addr] <= wb_data;
      if (wb_orphan) sb_err_q <= 1'b1;
      // Issue and retire on the same register cancel out.
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_inc[i] && !cnt_dec[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 2'd1;
        else if (cnt_dec[i] && !cnt_inc[i]) cnt[i] <= cnt[i] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb: stimulus queues expected outputs, a negedge monitor compares them.
module tb_id_regfile_sb;
  localparam int DW = 64;

  localparam logic [7:0] M_R1 = 8'h01, M_R2 = 8'h02, M_ST = 8'h04, M_IS = 8'h08;
  localparam logic [7:0] M_WRE = 8'h10, M_WME = 8'h20, M_WREG = 8'h40, M_ERR = 8'h80;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid, R1_use, R2_use, WRegEn_in, WMemEn_in, wb_en;
  logic [2:0]    R1_addr, R2_addr, WReg1_in, wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] R1_out_ID, R2_out_ID;
  logic          WRegEn_ID, WMemEn_ID, issue, stall, sb_err;
  logic [2:0]    WReg1_ID;

  id_regfile_sb #(.DATA_W(DW), .DEPTH(8), .MAX_INFL(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .R1_addr(R1_addr), .R2_addr(R2_addr), .R1_use(R1_use), .R2_use(R2_use),
    .WRegEn_in(WRegEn_in), .WMemEn_in(WMemEn_in), .WReg1_in(WReg1_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .R1_out_ID(R1_out_ID), .R2_out_ID(R2_out_ID),
    .WRegEn_ID(WRegEn_ID), .WMemEn_ID(WMemEn_ID), .WReg1_ID(WReg1_ID),
    .issue(issue), .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [7:0]    mask;
    logic [DW-1:0] r1, r2;
    logic          st, is, wre, wme;
    logic [2:0]    wreg;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic drive(input logic v, input logic r1u, input logic [2:0] r1a,
                       input logic r2u, input logic [2:0] r2a,
                       input logic wre, input logic wme, input logic [2:0] wd,
                       input logic wb, input logic [2:0] wa, input logic [DW-1:0] wdat);
    id_valid = v;   R1_use = r1u;   R1_addr = r1a;  R2_use = r2u; R2_addr = r2a;
    WRegEn_in = wre; WMemEn_in = wme; WReg1_in = wd;
    wb_en = wb;     wb_addr = wa;   wb_data = wdat;
  endtask

  task automatic expect_out(input string name, input logic [7:0] mask,
                            input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                            input logic st, input logic is, input logic wre, input logic wme,
                            input logic [2:0] wreg, input logic err);
    exp_t e;
    e.name = name; e.mask = mask; e.r1 = r1; e.r2 = r2; e.st = st; e.is = is;
    e.wre = wre; e.wme = wme; e.wreg = wreg; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input string field,
                     input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.mask[0]) chk(e.name, "R1_out_ID", R1_out_ID, e.r1);
        if (e.mask[1]) chk(e.name, "R2_out_ID", R2_out_ID, e.r2);
        if (e.mask[2]) chk(e.name, "stall", DW'(stall), DW'(e.st));
        if (e.mask[3]) chk(e.name, "issue", DW'(issue), DW'(e.is));
        if (e.mask[4]) chk(e.name, "WRegEn_ID", DW'(WRegEn_ID), DW'(e.wre));
        if (e.mask[5]) chk(e.name, "WMemEn_ID", DW'(WMemEn_ID), DW'(e.wme));
        if (e.mask[6]) chk(e.name, "WReg1_ID", DW'(WReg1_ID), DW'(e.wreg));
        if (e.mask[7]) chk(e.name, "sb_err", DW'(sb_err), DW'(e.err));
      end
    end
  end

  initial begin : stim
    drive(0, 0, 3'd0, 0, 3'd1, 0, 0, 3'd0, 0, 3'd0, '0);
    #1;
    rst = 1'b1;
    expect_out("reset", M_R1 | M_R2 | M_ST | M_IS | M_WRE | M_WME | M_ERR, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    step(); rst = 1'b0;

    // Write r2 then read it back; orphan writeback raises sb_err
    step(); drive(0, 0, 3'd2, 0, 3'd0, 0, 0, 3'd0, 1, 3'd2, 64'hDEAD);
    expect_out("wb_r2", M_R1 | M_ST | M_IS | M_ERR, 64'hDEAD, 0, 0, 0, 0, 0, 3'd0, 0);
    step(); drive(1, 1, 3'd2, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, '0);
    expect_out("read_r2", M_R1 | M_ST | M_IS | M_WRE | M_ERR, 64'hDEAD, 0, 0, 1, 0, 0, 3'd0, 1);
    step(); drive(1, 1, 3'd2, 1, 3'd5, 0, 0, 3'd0, 1, 3'd5, 64'h1234);
    expect_out("bypass_r5", M_R1 | M_R2 | M_ST | M_IS | M_ERR, 64'hDEAD, 64'h1234, 0, 1, 0, 0, 3'd0, 1);
    step(); rst = 1'b1; drive(0, 0, 3'd2, 0, 3'd5, 0, 0, 3'd0, 0, 3'd0, '0);
    expect_out("rst_clear", M_R1 | M_R2 | M_ST | M_IS | M_ERR, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    step(); rst = 1'b0;

    // RAW hazard on r3
    step(); drive(1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd3, 0, 3'd0, '0);
    expect_out("issue_w_r3", M_ST | M_IS | M_WRE | M_WME | M_WREG, 0, 0, 0, 1, 1, 0, 3'd3, 0);
    step(); drive(1, 1, 3'd3, 0, 3'd0, 1, 1, 3'd1, 0, 3'd0, '0);
    expect_out("raw_stall", M_ST | M_IS | M_WRE | M_WME | M_WREG, 0, 0, 1, 0, 0, 0, 3'd1, 0);
    step();
    expect_out("raw_stall_hold", M_ST | M_IS | M_WRE, 0, 0, 1, 0, 0, 0, 3'd1, 0);
    step(); drive(1, 1, 3'd3, 0, 3'd0, 1, 1, 3'd1, 1, 3'd3, 64'hCAFE);
    expect_out("raw_release", M_R1 | M_ST | M_IS | M_WRE | M_WME | M_WREG | M_ERR,
               64'hCAFE, 0, 0, 1, 1, 1, 3'd1, 0);

    // Saturate r4
    for (int k = 0; k < 3; k++) begin
      step(); drive(1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd4, 0, 3'd0, '0);
      expect_out($sformatf("sat_issue%0d", k), M_ST | M_IS | M_WRE, 0, 0, 0, 1, 1, 0, 3'd4, 0);
    end
    step();
    expect_out("sat_stall", M_ST | M_IS | M_WRE, 0, 0, 1, 0, 0, 0, 3'd4, 0);
    step(); drive(1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd4, 1, 3'd4, 64'h44);
    expect_out("sat_stall_wb", M_ST | M_IS | M_WRE | M_ERR, 0, 0, 1, 0, 0, 0, 3'd4, 0);
    step(); drive(1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd4, 0, 3'd0, '0);
    expect_out("sat_release", M_ST | M_IS | M_WRE, 0, 0, 0, 1, 1, 0, 3'd4, 0);

    // Simultaneous issue/retire on r6, then orphan writeback to r7
    step(); drive(1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd6, 0, 3'd0, '0);
    expect_out("issue_w_r6", M_ST | M_IS | M_WRE, 0, 0, 0, 1, 1, 0, 3'd6, 0);
    step(); drive(1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd6, 1, 3'd6, 64'h66);
    expect_out("issue_wb_r6", M_ST | M_IS | M_WRE | M_ERR, 0, 0, 0, 1, 1, 0, 3'd6, 0);
    step(); drive(1, 1, 3'd6, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, '0);
    expect_out("r6_still_busy", M_R1 | M_ST | M_IS, 64'h66, 0, 1, 0, 0, 0, 3'd0, 0);
    step(); drive(1, 1, 3'd6, 0, 3'd0, 0, 0, 3'd0, 1, 3'd6, 64'h67);
    expect_out("r6_last_wb", M_R1 | M_ST | M_IS | M_ERR, 64'h67, 0, 0, 1, 0, 0, 3'd0, 0);
    step(); drive(0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 3'd7, 64'h77);
    expect_out("wb_r7", M_ST | M_IS | M_ERR, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    step(); drive(0, 0, 3'd0, 0, 3'd7, 0, 0, 3'd0, 0, 3'd0, '0);
    expect_out("sb_err_set", M_R2 | M_ERR, 0, 64'h77, 0, 0, 0, 0, 3'd0, 1);
    step();
    expect_out("sb_err_sticky", M_ERR, 0, 0, 0, 0, 0, 0, 3'd0, 1);

    // Async reset in the middle of a stall with cnt[3]=2 and cnt[4]=3
    step(); drive(1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd3, 0, 3'd0, '0);
    expect_out("issue_w_r3_a", M_IS, 0, 0, 0, 1, 0, 0, 3'd0, 0);
    step();
    expect_out("issue_w_r3_b", M_IS, 0, 0, 0, 1, 0, 0, 3'd0, 0);
    step(); drive(1, 1, 3'd4, 1, 3'd3, 0, 0, 3'd0, 0, 3'd0, '0);
    expect_out("stall_cnt3_2", M_ST | M_IS | M_ERR, 0, 0, 1, 0, 0, 0, 3'd0, 1);
    step(); rst = 1'b1;
    expect_out("async_rst", M_R1 | M_R2 | M_ST | M_IS | M_ERR, 0, 0, 0, 1, 0, 0, 3'd0, 0);
    step(); drive(1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd5, 1, 3'd3, 64'h99);
    expect_out("rst_ignore", M_ST | M_IS | M_WRE | M_ERR, 0, 0, 0, 1, 1, 0, 3'd5, 0);
    step(); rst = 1'b0; drive(1, 1, 3'd3, 1, 3'd5, 1, 0, 3'd5, 0, 3'd0, '0);
    expect_out("post_rst", M_R1 | M_R2 | M_ST | M_IS | M_ERR, 0, 0, 0, 1, 0, 0, 3'd0, 0);
    step(); drive(1, 1, 3'd5, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, '0);
    expect_out("post_rst_raw", M_ST | M_IS, 0, 0, 1, 0, 0, 0, 3'd0, 0);
    step(); drive(0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 3'd0, '0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations unchecked, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
